// File: rtl/low_tx_bridge.sv
// PCI-side TX bridge: buffers 32-bit words in a FIFO and serialises each word
// LSB-first onto the lower-board byte port with a fixed-width write strobe.
module low_tx_bridge #(
  parameter int unsigned DEPTH_LOG2    = 3,
  parameter int unsigned STROBE_CYCLES = 2
) (
  input  logic                  PCI_CLK,
  input  logic                  PCI_RST,
  input  logic                  WR_STB,
  input  logic [31:0]           WR_DATA,
  input  logic                  CLR_STB,
  input  logic                  LOW_busy,
  output logic                  LOW_w,
  output logic                  LOW_r,
  output logic [7:0]            LOW_data,
  output logic [DEPTH_LOG2:0]   LEVEL,
  output logic                  FULL,
  output logic                  EMPTY,
  output logic                  OVF,
  output logic                  TX_BUSY
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned AW    = DEPTH_LOG2;
  localparam int unsigned LW    = DEPTH_LOG2 + 1;
  localparam int unsigned CW    = 4;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD} state_t;

  state_t          r_state, w_state_nxt;
  logic [31:0]     r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [LW-1:0]   r_level, w_level_nxt;
  logic            r_full, r_empty, r_ovf;
  logic [31:0]     r_shift, w_shift_nxt;
  logic [1:0]      r_idx, w_idx_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic            r_low_w, r_tx_busy;
  logic            w_push, w_pop, w_can_pop;

  assign LOW_w    = r_low_w;
  assign LOW_r    = 1'b0;
  assign LOW_data = r_shift[7:0];
  assign LEVEL    = r_level;
  assign FULL     = r_full;
  assign EMPTY    = r_empty;
  assign OVF      = r_ovf;
  assign TX_BUSY  = r_tx_busy;

  assign w_push    = WR_STB & ~r_full & ~CLR_STB;
  assign w_can_pop = ~r_empty & ~LOW_busy;

  // Next state; a word is fetched from IDLE or straight out of the last HOLD.
  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt;
    w_pop       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_can_pop) begin
          w_pop       = 1'b1;
          w_shift_nxt = r_mem[r_rd_ptr];
          w_idx_nxt   = 2'd0;
          w_state_nxt = S_SETUP;
        end
      end
      S_SETUP: begin
        if (!LOW_busy) begin
          w_cnt_nxt   = CW'(STROBE_CYCLES - 1);
          w_state_nxt = S_STROBE;
        end
      end
      S_STROBE: begin
        if (r_cnt == '0) w_state_nxt = S_HOLD;
        else             w_cnt_nxt   = r_cnt - CW'(1);
      end
      S_HOLD: begin
        if (r_idx != 2'd3) begin
          w_idx_nxt   = r_idx + 2'd1;
          w_shift_nxt = {8'h00, r_shift[31:8]};
          w_state_nxt = S_SETUP;
        end else if (w_can_pop) begin
          w_pop       = 1'b1;
          w_shift_nxt = r_mem[r_rd_ptr];
          w_idx_nxt   = 2'd0;
          w_state_nxt = S_SETUP;
        end else begin
          w_shift_nxt = '0;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // Flush aborts any word in flight and drops the same-cycle push.
    if (CLR_STB) begin
      w_pop       = 1'b0;
      w_shift_nxt = '0;
      w_idx_nxt   = 2'd0;
      w_state_nxt = S_IDLE;
    end
  end

  always_comb begin
    w_level_nxt = r_level;
    if (CLR_STB)             w_level_nxt = '0;
    else if (w_push && !w_pop) w_level_nxt = r_level + LW'(1);
    else if (!w_push && w_pop) w_level_nxt = r_level - LW'(1);
  end

  always_ff @(posedge PCI_CLK) begin
    if (PCI_RST) begin
      r_state   <= S_IDLE;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_level   <= '0;
      r_full    <= 1'b0;
      r_empty   <= 1'b1;
      r_ovf     <= 1'b0;
      r_shift   <= '0;
      r_idx     <= '0;
      r_cnt     <= '0;
      r_low_w   <= 1'b0;
      r_tx_busy <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_shift   <= w_shift_nxt;
      r_idx     <= w_idx_nxt;
      r_cnt     <= w_cnt_nxt;
      r_low_w   <= (w_state_nxt == S_STROBE);
      r_tx_busy <= (w_state_nxt != S_IDLE);
      r_level   <= w_level_nxt;
      r_full    <= (w_level_nxt == LW'(DEPTH));
      r_empty   <= (w_level_nxt == '0);
      if (CLR_STB) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_ovf    <= 1'b0;
      end else begin
        if (w_push)           r_wr_ptr <= r_wr_ptr + AW'(1);
        if (w_pop)            r_rd_ptr <= r_rd_ptr + AW'(1);
        if (WR_STB && r_full) r_ovf    <= 1'b1;
      end
    end
  end

  // Storage needs no reset; pointers and level define what is valid.
  always_ff @(posedge PCI_CLK) begin
    if (w_push && !PCI_RST) r_mem[r_wr_ptr] <= WR_DATA;
  end

endmodule

// File: tb/tb_low_tx_bridge.sv
// Bench for low_tx_bridge: directed stimulus queues expected bytes, a monitor
// checks every LOW_w pulse; the stimulus thread checks FIFO/FSM timing points.
module tb_low_tx_bridge;

  localparam int unsigned STROBE = 2;

  logic        clk = 1'b0;
  logic        PCI_RST = 1'b1;
  logic        WR_STB = 1'b0;
  logic [31:0] WR_DATA = '0;
  logic        CLR_STB = 1'b0;
  logic        LOW_busy = 1'b0;
  logic        LOW_w, LOW_r;
  logic [7:0]  LOW_data;
  logic [3:0]  LEVEL;
  logic        FULL, EMPTY, OVF, TX_BUSY;

  int          checks = 0;
  int          errors = 0;
  int          rx_bytes = 0;
  logic [7:0]  exp_q[$];

  logic        mon_prev = 1'b0;
  int          mon_width = 0;
  logic [7:0]  mon_cur = '0;

  low_tx_bridge #(.DEPTH_LOG2(3), .STROBE_CYCLES(STROBE)) dut (
    .PCI_CLK(clk), .PCI_RST(PCI_RST), .WR_STB(WR_STB), .WR_DATA(WR_DATA),
    .CLR_STB(CLR_STB), .LOW_busy(LOW_busy), .LOW_w(LOW_w), .LOW_r(LOW_r),
    .LOW_data(LOW_data), .LEVEL(LEVEL), .FULL(FULL), .EMPTY(EMPTY),
    .OVF(OVF), .TX_BUSY(TX_BUSY)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_exp(input logic [31:0] w);
    for (int b = 0; b < 4; b++) exp_q.push_back(w[8*b +: 8]);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((TX_BUSY || !EMPTY) && n < budget) begin
      step(1);
      n++;
    end
    chk("wait_idle_timeout", 32'(TX_BUSY || !EMPTY), 32'd0);
    step(2);
  endtask

  // Monitor: every rising LOW_w must carry the next queued byte.
  initial begin
    forever begin
      @(negedge clk);
      if (PCI_RST) begin
        mon_prev  = 1'b0;
        mon_width = 0;
      end else begin
        if (LOW_w && !mon_prev) begin
          rx_bytes++;
          chk("mon_low_r", 32'(LOW_r), 32'd0);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL mon_unexpected_byte: got %0h expected no strobe", LOW_data);
          end else begin
            chk("mon_byte", 32'(LOW_data), 32'(exp_q.pop_front()));
          end
          mon_cur   = LOW_data;
          mon_width = 1;
        end else if (LOW_w) begin
          mon_width++;
          chk("mon_data_stable", 32'(LOW_data), 32'(mon_cur));
        end else if (mon_prev) begin
          chk("mon_width", 32'(mon_width), 32'(STROBE));
        end
        mon_prev = LOW_w;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int nbusy;
    step(3);
    PCI_RST = 1'b0;
    step(1);
    chk("rst_level", 32'(LEVEL), 32'd0);
    chk("rst_empty", 32'(EMPTY), 32'd1);
    chk("rst_full", 32'(FULL), 32'd0);
    chk("rst_ovf", 32'(OVF), 32'd0);
    chk("rst_busy", 32'(TX_BUSY), 32'd0);
    chk("rst_low_w", 32'(LOW_w), 32'd0);
    chk("rst_data", 32'(LOW_data), 32'd0);

    // Single word, first-byte latency and word duration.
    WR_STB = 1'b1; WR_DATA = 32'hA1B2C3D4; push_exp(WR_DATA);
    step(1); WR_STB = 1'b0;
    chk("s1_c1_level", 32'(LEVEL), 32'd1);
    chk("s1_c1_busy", 32'(TX_BUSY), 32'd0);
    step(1);
    chk("s1_c2_level", 32'(LEVEL), 32'd0);
    chk("s1_c2_busy", 32'(TX_BUSY), 32'd1);
    chk("s1_c2_data", 32'(LOW_data), 32'hD4);
    chk("s1_c2_low_w", 32'(LOW_w), 32'd0);
    step(1); chk("s1_c3_low_w", 32'(LOW_w), 32'd1);
    step(1); chk("s1_c4_low_w", 32'(LOW_w), 32'd1);
    step(1); chk("s1_c5_low_w", 32'(LOW_w), 32'd0);
    chk("s1_c5_data", 32'(LOW_data), 32'hD4);
    step(1); chk("s1_c6_data", 32'(LOW_data), 32'hC3);
    step(11); chk("s1_c17_busy", 32'(TX_BUSY), 32'd1);
    step(1); chk("s1_c18_busy", 32'(TX_BUSY), 32'd0);
    chk("s1_c18_data", 32'(LOW_data), 32'd0);
    step(2);

    // Fill while stalled, overflow, then drop a push to a full FIFO on a pop cycle.
    LOW_busy = 1'b1;
    for (int i = 0; i < 9; i++) begin
      WR_STB = 1'b1;
      WR_DATA = 32'h03020100 + 32'(i) * 32'h10101010;
      if (i < 8) push_exp(WR_DATA);
      step(1);
      if (i == 7) begin
        chk("s2_level8", 32'(LEVEL), 32'd8);
        chk("s2_full8", 32'(FULL), 32'd1);
        chk("s2_ovf8", 32'(OVF), 32'd0);
      end
    end
    WR_STB = 1'b0;
    chk("s2_level9", 32'(LEVEL), 32'd8);
    chk("s2_ovf9", 32'(OVF), 32'd1);
    LOW_busy = 1'b0; WR_STB = 1'b1; WR_DATA = 32'hDEADBEEF;
    step(1); WR_STB = 1'b0;
    chk("s2_pop_drop_level", 32'(LEVEL), 32'd7);
    chk("s2_pop_drop_full", 32'(FULL), 32'd0);
    chk("s2_pop_drop_ovf", 32'(OVF), 32'd1);
    wait_idle(200);
    chk("s2_all_sent", 32'(exp_q.size()), 32'd0);

    // Back-to-back words with a simultaneous push/pop.
    WR_STB = 1'b1; WR_DATA = 32'h44332211; push_exp(WR_DATA);
    step(1);
    WR_DATA = 32'h88776655; push_exp(WR_DATA);
    chk("s4_c1_level", 32'(LEVEL), 32'd1);
    step(1); WR_STB = 1'b0;
    chk("s4_c2_level", 32'(LEVEL), 32'd1);
    nbusy = 0;
    for (int c = 2; c <= 34; c++) begin
      if (TX_BUSY) nbusy++;
      if (c == 18) begin
        chk("s4_c18_data", 32'(LOW_data), 32'h55);
        chk("s4_c18_level", 32'(LEVEL), 32'd0);
      end
      if (c < 34) step(1);
    end
    chk("s4_busy_cycles", 32'(nbusy), 32'd32);
    chk("s4_c34_busy", 32'(TX_BUSY), 32'd0);
    step(2);

    // Stall in SETUP of byte 2 for five cycles.
    WR_STB = 1'b1; WR_DATA = 32'hCAFEF00D; push_exp(WR_DATA);
    step(1); WR_STB = 1'b0;
    step(9);
    chk("s3_c10_data", 32'(LOW_data), 32'hFE);
    LOW_busy = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step(1);
      chk("s3_stall_low_w", 32'(LOW_w), 32'd0);
      chk("s3_stall_data", 32'(LOW_data), 32'hFE);
    end
    LOW_busy = 1'b0;
    step(1);
    chk("s3_resume_low_w", 32'(LOW_w), 32'd1);
    chk("s3_resume_data", 32'(LOW_data), 32'hFE);
    wait_idle(60);

    // Flush during STROBE of byte 1 with a queued word and a same-cycle push.
    chk("s5_ovf_before", 32'(OVF), 32'd1);
    WR_STB = 1'b1; WR_DATA = 32'h5A6B7C8D; push_exp(WR_DATA);
    step(1); WR_DATA = 32'h0F1E2D3C;
    step(1); WR_STB = 1'b0;
    step(6);
    chk("s5_c8_low_w", 32'(LOW_w), 32'd1);
    chk("s5_c8_data", 32'(LOW_data), 32'h7C);
    CLR_STB = 1'b1; WR_STB = 1'b1; WR_DATA = 32'h99999999;
    exp_q.delete();
    step(1); CLR_STB = 1'b0; WR_STB = 1'b0;
    chk("s5_low_w", 32'(LOW_w), 32'd0);
    chk("s5_level", 32'(LEVEL), 32'd0);
    chk("s5_ovf", 32'(OVF), 32'd0);
    chk("s5_busy", 32'(TX_BUSY), 32'd0);
    chk("s5_empty", 32'(EMPTY), 32'd1);
    chk("s5_data", 32'(LOW_data), 32'd0);
    step(10);
    chk("s5_later_level", 32'(LEVEL), 32'd0);
    chk("s5_later_busy", 32'(TX_BUSY), 32'd0);

    // Reset during STROBE of byte 1, then a clean word afterwards.
    WR_STB = 1'b1; WR_DATA = 32'h13579BDF; push_exp(WR_DATA);
    step(1); WR_DATA = 32'h2468ACE0;
    step(3); WR_STB = 1'b0;
    step(4);
    chk("s6_c8_low_w", 32'(LOW_w), 32'd1);
    chk("s6_c8_level", 32'(LEVEL), 32'd3);
    PCI_RST = 1'b1; WR_STB = 1'b1; WR_DATA = 32'h77777777;
    exp_q.delete();
    step(1); PCI_RST = 1'b0; WR_STB = 1'b0;
    chk("s6_low_w", 32'(LOW_w), 32'd0);
    chk("s6_level", 32'(LEVEL), 32'd0);
    chk("s6_ovf", 32'(OVF), 32'd0);
    chk("s6_busy", 32'(TX_BUSY), 32'd0);
    chk("s6_data", 32'(LOW_data), 32'd0);
    step(3);
    WR_STB = 1'b1; WR_DATA = 32'hFEDCBA98; push_exp(WR_DATA);
    step(1); WR_STB = 1'b0;
    chk("s6_new_level", 32'(LEVEL), 32'd1);
    wait_idle(60);

    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("final_rx_bytes", 32'(rx_bytes), 32'd56);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/low_tx_bridge.md
LOW_TX_BRIDGE -- requirements
Module: low_tx_bridge

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 3, meaning FIFO depth is 2^DEPTH_LOG2 32-bit words.
REQ-002 SHALL have parameter STROBE_CYCLES, default 2, range 1-15, meaning the number of cycles LOW_w is high per byte.
REQ-003 SHALL have port PCI_CLK, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port PCI_RST, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port WR_STB, input, 1 bit: one-cycle push of WR_DATA, driven by the PCI target on a MEM/IO data-phase write to the TX register.
REQ-006 SHALL have port WR_DATA, input, 32 bits: word to transmit, sampled when WR_STB=1.
REQ-007 SHALL have port CLR_STB, input, 1 bit: one-cycle flush/abort request.
REQ-008 SHALL have port LOW_busy, input, 1 bit: lower board not ready; stalls byte issue.
REQ-009 SHALL have port LOW_w, output, 1 bit: byte write strobe to the lower board.
REQ-010 SHALL have port LOW_r, output, 1 bit: read strobe, constant 0.
REQ-011 SHALL have port LOW_data, output, 8 bits: byte to the lower board.
REQ-012 SHALL have port LEVEL, output, DEPTH_LOG2+1 bits: number of words held in the FIFO.
REQ-013 SHALL have ports FULL, EMPTY, OVF and TX_BUSY, each output, 1 bit: FIFO full, FIFO empty, sticky overflow, and FSM not in IDLE.

Function
REQ-014 SHALL push WR_DATA into the FIFO at the edge ending a cycle where WR_STB=1, FULL=0 and CLR_STB=0.
REQ-015 SHALL drop a WR_STB that arrives while FULL=1 and set OVF=1, even if a pop occurs in that same cycle.
REQ-016 SHALL leave LEVEL unchanged on a simultaneous accepted push and pop.
REQ-017 SHALL drive FULL=1 exactly when LEVEL=2^DEPTH_LOG2 and EMPTY=1 exactly when LEVEL=0, with read/write pointers wrapping modulo the depth.
REQ-018 SHALL implement FSM states IDLE, SETUP, STROBE and HOLD.
REQ-019 SHALL, in IDLE with EMPTY=0 and LOW_busy=0, pop one word into a 32-bit shift register, set byte index to 0, and go to SETUP.
REQ-020 SHALL, in SETUP, drive LOW_data with the current byte and LOW_w=0; go to STROBE when LOW_busy=0, otherwise stay in SETUP.
REQ-021 SHALL, in STROBE, drive LOW_w=1 with LOW_data stable for exactly STROBE_CYCLES cycles, ignoring LOW_busy, then go to HOLD.
REQ-022 SHALL, in HOLD, drive LOW_w=0 with LOW_data held for 1 cycle; if byte index<3, increment it and go to SETUP; if byte index=3, apply the IDLE rule directly (pop and go to SETUP with no gap cycle, else go to IDLE).
REQ-023 SHALL send bytes LSB first (WR_DATA[7:0] first, [31:24] last).
REQ-024 SHALL take STROBE_CYCLES+2 cycles per byte when unstalled and 4*(STROBE_CYCLES+2) cycles per word.
REQ-025 SHALL, with the FIFO empty and IDLE, for WR_STB in cycle 0: show LEVEL=1 in cycle 1, enter SETUP in cycle 2 (LEVEL=0, LOW_data=byte0), and drive LOW_w=1 in cycles 3..2+STROBE_CYCLES.
REQ-026 SHALL, on CLR_STB=1, at the next edge empty the FIFO (LEVEL=0), clear OVF, force the FSM to IDLE with LOW_w=0, discard the partial word, and ignore a same-cycle WR_STB.
REQ-027 SHALL drive LOW_data=0 in IDLE.
REQ-028 SHALL drive TX_BUSY=1 in every state other than IDLE.
REQ-029 SHALL hold LOW_r=0 at all times.

Reset
REQ-030 SHALL, while PCI_RST=1 at an edge, set the FSM to IDLE, pointers and LEVEL to 0, EMPTY=1, FULL=0, OVF=0, TX_BUSY=0, LOW_w=0 and LOW_data=0, and ignore all other inputs.
REQ-031 SHALL apply reset mid-word identically to CLR_STB: the partial word is lost and LOW_w drops at that edge.

Verification
REQ-032 SHALL verify: WR_DATA=32'hA1B2C3D4 pushed once, LOW_busy=0, defaults -> bytes D4,C3,B2,A1 each with a 2-cycle LOW_w pulse, first LOW_w in cycle 3, TX_BUSY=0 from cycle 18.
REQ-033 SHALL verify: LOW_busy=1 and 9 consecutive pushes -> LEVEL=8 and FULL=1 after the 8th push; 9th push dropped, OVF=1; after release, exactly 8 words sent in order.
REQ-034 SHALL verify: LOW_busy raised during SETUP of byte 2 for 5 cycles -> FSM held in SETUP, LOW_data stable, no LOW_w, then resumes with byte 2.
REQ-035 SHALL verify: two words pushed back-to-back -> 32 cycles of output with no IDLE gap between the HOLD of byte 3 and the SETUP of word 2.
REQ-036 SHALL verify: CLR_STB or PCI_RST asserted during STROBE of byte 1 -> LOW_w=0, LEVEL=0, OVF=0 and TX_BUSY=0 at the next edge, and a same-cycle WR_STB is not stored.
